// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and default timing for button_debouncer
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_HIGH = 2'b01,
    PRESSED   = 2'b11,
    WAIT_LOW  = 2'b10
  } btn_state_t;

  // Defaults assume a 125 MHz ClkIn: 10 ms window, 500 ms delay, 100 ms repeat
  localparam int unsigned DEF_CNT_W         = 21;
  localparam int unsigned DEF_STABLE_CNT    = 1250000;
  localparam int unsigned DEF_RPT_W         = 26;
  localparam int unsigned DEF_REPEAT_DELAY  = 62500000;
  localparam int unsigned DEF_REPEAT_PERIOD = 12500000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchronizer plus stability-window FSM; auto-repeat under BTN_AUTOREPEAT_EN
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned STABLE_CNT    = DEF_STABLE_CNT,
  parameter int unsigned RPT_W         = DEF_RPT_W,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic ClkIn,
  input  logic Rst,
  input  logic BtnIn,
  output logic BtnLevel,
  output logic BtnRise,
  output logic BtnFall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             r_s1, r_s2;
  btn_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, w_level_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] r_rpt, w_rpt_nxt;
  logic             r_rpt_first, w_rpt_first_nxt;
  logic [RPT_W-1:0] w_rpt_tgt;

  assign w_rpt_tgt = r_rpt_first ? RPT_FIRST : RPT_NEXT;
`endif

  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1    <= BtnIn;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) begin
      r_rpt       <= '0;
      r_rpt_first <= 1'b1;
    end else begin
      r_rpt       <= w_rpt_nxt;
      r_rpt_first <= w_rpt_first_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_s2) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!r_s2) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (r_s2) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase

`ifdef BTN_AUTOREPEAT_EN
    // Repeats keep running through release bounces; the final release wins over a coincident repeat
    w_rpt_nxt       = r_rpt;
    w_rpt_first_nxt = r_rpt_first;
    if (r_state == WAIT_HIGH && w_state_nxt == PRESSED) begin
      w_rpt_nxt       = '0;
      w_rpt_first_nxt = 1'b1;
    end else if ((r_state == PRESSED || r_state == WAIT_LOW) && w_state_nxt != IDLE) begin
      if (r_rpt == w_rpt_tgt) begin
        w_rise_nxt      = 1'b1;
        w_rpt_nxt       = '0;
        w_rpt_first_nxt = 1'b0;
      end else begin
        w_rpt_nxt = r_rpt + RPT_W'(1);
      end
    end
`endif
  end

  assign BtnLevel = r_level;
  assign BtnRise  = r_rise;
  assign BtnFall  = r_fall;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - N_BTN independent debounce channels; BTN_AUTOREPEAT_EN adds press auto-repeat
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN         = 2,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned STABLE_CNT    = DEF_STABLE_CNT,
  parameter int unsigned RPT_W         = DEF_RPT_W,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic             ClkIn,
  input  logic             Rst,
  input  logic [N_BTN-1:0] BtnIn,
  output logic [N_BTN-1:0] BtnLevel,
  output logic [N_BTN-1:0] BtnRise,
  output logic [N_BTN-1:0] BtnFall
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_channel #(
      .CNT_W        (CNT_W),
      .STABLE_CNT   (STABLE_CNT),
      .RPT_W        (RPT_W),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .ClkIn   (ClkIn),
      .Rst     (Rst),
      .BtnIn   (BtnIn[g]),
      .BtnLevel(BtnLevel[g]),
      .BtnRise (BtnRise[g]),
      .BtnFall (BtnFall[g])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer (STABLE_CNT=4, N_BTN=2)
module tb_button_debouncer;

  localparam int N_BTN = 2;

  logic             ClkIn = 1'b0;
  logic             Rst   = 1'b1;
  logic [N_BTN-1:0] BtnIn = '0;
  logic [N_BTN-1:0] BtnLevel, BtnRise, BtnFall;

  int errors = 0;
  int checks = 0;

  button_debouncer #(
    .N_BTN        (N_BTN),
    .CNT_W        (21),
    .STABLE_CNT   (4),
    .RPT_W        (8),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5)
  ) dut (
    .ClkIn   (ClkIn),
    .Rst     (Rst),
    .BtnIn   (BtnIn),
    .BtnLevel(BtnLevel),
    .BtnRise (BtnRise),
    .BtnFall (BtnFall)
  );

  always #5 ClkIn = ~ClkIn;

  task automatic tick();
    @(posedge ClkIn);
    #1;
  endtask

  task automatic do_reset();
    BtnIn = '0;
    Rst   = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst   = 1'b1;
    BtnIn = 2'b11;
    tick();
    tick();
    tick();
    checks++;
    if ({BtnLevel, BtnRise, BtnFall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got lvl=%b rise=%b fall=%b want all 0", BtnLevel, BtnRise, BtnFall);
    end
    do_reset();
  endtask

  task automatic test_clean_press();
    BtnIn = 2'b01;
    for (int e = 0; e <= 7; e++) begin
      tick();
      checks++;
      if (BtnRise !== ((e == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL press_rise e=%0d: got %b want %b", e, BtnRise, (e == 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (BtnLevel !== ((e >= 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL press_level e=%0d: got %b want %b", e, BtnLevel, (e >= 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (BtnFall !== 2'b00) begin
        errors++;
        $display("FAIL press_fall e=%0d: got %b want 00", e, BtnFall);
      end
    end
    BtnIn = 2'b00;
    for (int e = 0; e <= 9; e++) begin
      tick();
      checks++;
      if (BtnFall !== ((e == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL release_fall e=%0d: got %b want %b", e, BtnFall, (e == 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (BtnLevel !== ((e < 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL release_level e=%0d: got %b want %b", e, BtnLevel, (e < 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (BtnRise !== 2'b00) begin
        errors++;
        $display("FAIL release_rise e=%0d: got %b want 00", e, BtnRise);
      end
    end
  endtask

  task automatic test_glitch();
    BtnIn = 2'b01;
    for (int e = 0; e < 15; e++) begin
      if (e == 3) BtnIn = 2'b00;
      tick();
      checks++;
      if ({BtnLevel, BtnRise, BtnFall} !== 6'b0) begin
        errors++;
        $display("FAIL glitch e=%0d: got lvl=%b rise=%b fall=%b want all 0", e, BtnLevel, BtnRise, BtnFall);
      end
    end
  endtask

  task automatic test_bouncy_release();
    logic [7:0] seq;
    seq   = 8'b0000_0010;
    BtnIn = 2'b01;
    for (int e = 0; e <= 6; e++) tick();
    checks++;
    if (BtnLevel !== 2'b01 || BtnRise !== 2'b01) begin
      errors++;
      $display("FAIL bounce_setup: got lvl=%b rise=%b want 01/01", BtnLevel, BtnRise);
    end
    for (int t = 0; t < 14; t++) begin
      BtnIn = {1'b0, (t < 8) ? seq[t] : 1'b0};
      tick();
      checks++;
      if (BtnFall !== ((t == 8) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL bounce_fall t=%0d: got %b want %b", t, BtnFall, (t == 8) ? 2'b01 : 2'b00);
      end
      checks++;
      if (BtnRise !== 2'b00) begin
        errors++;
        $display("FAIL bounce_rise t=%0d: got %b want 00", t, BtnRise);
      end
    end
    checks++;
    if (BtnLevel !== 2'b00) begin
      errors++;
      $display("FAIL bounce_level_end: got %b want 00", BtnLevel);
    end
  endtask

  task automatic test_reset_mid_window();
    BtnIn = 2'b01;
    for (int e = 0; e <= 3; e++) tick();
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({BtnLevel, BtnRise, BtnFall} !== 6'b0) begin
      errors++;
      $display("FAIL rst_window: got lvl=%b rise=%b fall=%b want all 0", BtnLevel, BtnRise, BtnFall);
    end
    tick();
    Rst = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      checks++;
      if (BtnRise !== ((e == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL rst_rerise e=%0d: got %b want %b", e, BtnRise, (e == 6) ? 2'b01 : 2'b00);
      end
    end
    // Async clear must also drop an accepted level without waiting for an edge
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({BtnLevel, BtnRise, BtnFall} !== 6'b0) begin
      errors++;
      $display("FAIL rst_pressed: got lvl=%b rise=%b fall=%b want all 0", BtnLevel, BtnRise, BtnFall);
    end
    do_reset();
  endtask

  task automatic test_dual_press();
    BtnIn = 2'b11;
    for (int e = 0; e <= 7; e++) begin
      tick();
      checks++;
      if (BtnRise !== ((e == 6) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL dual_rise e=%0d: got %b want %b", e, BtnRise, (e == 6) ? 2'b11 : 2'b00);
      end
    end
    checks++;
    if (BtnLevel !== 2'b11) begin
      errors++;
      $display("FAIL dual_level: got %b want 11", BtnLevel);
    end
    do_reset();
  endtask

  task automatic test_autorepeat();
    logic [1:0] want;
    int         pulses;
    pulses = 0;
    BtnIn  = 2'b01;
    for (int e = 0; e <= 37; e++) begin
      tick();
      want = (e == 6) ? 2'b01 : 2'b00;
`ifdef BTN_AUTOREPEAT_EN
      if (e >= 16 && ((e - 16) % 5) == 0) want = 2'b01;
`endif
      if (BtnRise[0]) pulses++;
      checks++;
      if (BtnRise !== want) begin
        errors++;
        $display("FAIL repeat_rise e=%0d: got %b want %b", e, BtnRise, want);
      end
    end
    checks++;
`ifdef BTN_AUTOREPEAT_EN
    if (pulses != 6) begin
      errors++;
      $display("FAIL repeat_count: got %0d want 6", pulses);
    end
`else
    if (pulses != 1) begin
      errors++;
      $display("FAIL repeat_count: got %0d want 1", pulses);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bouncy_release();
    test_reset_mid_window();
    test_dual_press();
    test_autorepeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
